// File: rtl/laser_tx_scheduler_if.sv
// Host byte stream and two-lane transmitter link seen by the scheduler.
// master = scheduler side, slave = host/transmitter side.
interface laser_tx_scheduler_if;
    logic [7:0] in_data;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] data1_transmit;
    logic [7:0] data2_transmit;
    logic       data1_ready;
    logic       data2_ready;
    logic       tx_done;

    modport master (
        input  in_data, in_valid, tx_done,
        output in_ready, data1_transmit, data2_transmit, data1_ready, data2_ready
    );

    modport slave (
        output in_data, in_valid, tx_done,
        input  in_ready, data1_transmit, data2_transmit, data1_ready, data2_ready
    );
endinterface

// File: rtl/laser_tx_scheduler.sv
// Frames a host byte stream onto the two-lane laser transmitter: SOF, payload slots,
// per-lane XOR checksum, paced on tx_done with pad and done timeouts.
module laser_tx_scheduler #(
    parameter int unsigned FRAME_LEN    = 16,
    parameter int unsigned PAD_TIMEOUT  = 64,
    parameter int unsigned DONE_TIMEOUT = 4096,
    parameter int unsigned GAP_CYCLES   = 32
) (
    input  logic                        clock,
    input  logic                        reset,
    input  logic                        en,
    input  logic                        dual_lane,
    laser_tx_scheduler_if.master        bus,
    output logic                        frame_active,
    output logic                        frame_abort,
    output logic                        error,
    output logic [15:0]                 frames_sent
);

    localparam int unsigned PAD_W  = $clog2(PAD_TIMEOUT + 1);
    localparam int unsigned WAIT_W = $clog2(DONE_TIMEOUT + 1);
    localparam int unsigned GAP_W  = $clog2(GAP_CYCLES + 1);

    localparam logic [PAD_W-1:0]  PAD_LAST  = PAD_W'(PAD_TIMEOUT - 1);
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(DONE_TIMEOUT - 1);
    localparam logic [GAP_W-1:0]  GAP_LAST  = GAP_W'(GAP_CYCLES - 1);
    localparam logic [7:0]        SLOT_LAST = 8'(FRAME_LEN - 1);
    localparam logic [7:0]        SOF_BYTE  = 8'hA5;

    typedef enum logic [2:0] {
        S_IDLE,
        S_SOF,
        S_LOAD,
        S_SEND,
        S_WAIT,
        S_CHK,
        S_GAP
    } state_t;

    typedef enum logic [1:0] {
        T_HDR,
        T_PAY,
        T_CHK
    } tag_t;

    state_t state, state_next;
    tag_t   tag;

    logic              mode;
    logic              lane_sel;
    logic              abort_pend;
    logic [7:0]        slot_cnt;
    logic [7:0]        chk1, chk2;
    logic [7:0]        data1, data2;
    logic              rdy1, rdy2;
    logic [PAD_W-1:0]  pad_cnt;
    logic [WAIT_W-1:0] wait_cnt;
    logic [GAP_W-1:0]  gap_cnt;

    logic accept, pad_fire, done_now, abort_now, timeout_now;

    assign bus.in_ready       = (state == S_LOAD) && en;
    assign bus.data1_transmit = data1;
    assign bus.data2_transmit = data2;
    assign bus.data1_ready    = rdy1;
    assign bus.data2_ready    = rdy2;
    assign frame_active       = (state == S_SOF) || (state == S_LOAD) || (state == S_SEND) ||
                                (state == S_WAIT) || (state == S_CHK);

    always_ff @(posedge clock) begin
        if (reset) state <= S_IDLE;
        else       state <= state_next;
    end

    always_comb begin
        state_next  = state;
        accept      = 1'b0;
        pad_fire    = 1'b0;
        done_now    = 1'b0;
        abort_now   = 1'b0;
        timeout_now = 1'b0;
        case (state)
            S_IDLE: begin
                if (en && bus.in_valid && !error) state_next = S_SOF;
            end
            S_SOF: begin
                if (!en) begin
                    abort_now  = 1'b1;
                    state_next = S_IDLE;
                end else begin
                    state_next = S_SEND;
                end
            end
            S_LOAD: begin
                if (!en) begin
                    abort_now  = 1'b1;
                    state_next = S_IDLE;
                end else begin
                    accept = bus.in_valid;
                    if (accept && (lane_sel || !mode)) begin
                        state_next = S_SEND;
                    end else if (!accept && (pad_cnt == PAD_LAST)) begin
                        pad_fire   = 1'b1;
                        state_next = S_SEND;
                    end
                end
            end
            S_SEND: state_next = S_WAIT;
            S_WAIT: begin
                if (bus.tx_done) begin
                    done_now = 1'b1;
                    // A disable seen anywhere in SEND/WAIT takes effect only once the transfer ends
                    if ((tag != T_CHK) && (abort_pend || !en)) begin
                        abort_now  = 1'b1;
                        state_next = S_IDLE;
                    end else begin
                        case (tag)
                            T_HDR:   state_next = S_LOAD;
                            T_PAY:   state_next = (slot_cnt == SLOT_LAST) ? S_CHK : S_LOAD;
                            default: state_next = S_GAP;
                        endcase
                    end
                end else if (wait_cnt == WAIT_LAST) begin
                    timeout_now = 1'b1;
                    abort_now   = 1'b1;
                    state_next  = S_IDLE;
                end
            end
            S_CHK: state_next = S_SEND;
            S_GAP: begin
                if (gap_cnt == GAP_LAST) state_next = S_IDLE;
            end
            default: state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            tag         <= T_HDR;
            mode        <= 1'b0;
            lane_sel    <= 1'b0;
            abort_pend  <= 1'b0;
            slot_cnt    <= '0;
            chk1        <= '0;
            chk2        <= '0;
            data1       <= '0;
            data2       <= '0;
            rdy1        <= 1'b0;
            rdy2        <= 1'b0;
            pad_cnt     <= '0;
            wait_cnt    <= '0;
            gap_cnt     <= '0;
            frame_abort <= 1'b0;
            error       <= 1'b0;
            frames_sent <= '0;
        end else begin
            frame_abort <= abort_now;
            pad_cnt     <= '0;
            wait_cnt    <= '0;
            gap_cnt     <= '0;
            case (state)
                S_IDLE: begin
                    if (state_next == S_SOF) begin
                        mode       <= dual_lane;
                        chk1       <= '0;
                        chk2       <= '0;
                        slot_cnt   <= '0;
                        lane_sel   <= 1'b0;
                        abort_pend <= 1'b0;
                    end
                end
                S_SOF: begin
                    if (state_next == S_SEND) begin
                        data1 <= SOF_BYTE;
                        data2 <= mode ? SOF_BYTE : 8'h00;
                        tag   <= T_HDR;
                        rdy1  <= 1'b1;
                        rdy2  <= mode;
                    end
                end
                S_LOAD: begin
                    if (!en) begin
                        lane_sel <= 1'b0;
                    end else if (accept) begin
                        if (!lane_sel) begin
                            data1    <= bus.in_data;
                            chk1     <= chk1 ^ bus.in_data;
                            lane_sel <= mode;
                        end else begin
                            data2    <= bus.in_data;
                            chk2     <= chk2 ^ bus.in_data;
                            lane_sel <= 1'b0;
                        end
                    end else if (pad_fire) begin
                        // Zero-fill every slot not yet loaded; checksums untouched
                        if (!lane_sel) data1 <= 8'h00;
                        data2    <= 8'h00;
                        lane_sel <= 1'b0;
                    end else begin
                        pad_cnt <= pad_cnt + 1'b1;
                    end
                    if (state_next == S_SEND) begin
                        tag  <= T_PAY;
                        rdy1 <= 1'b1;
                        rdy2 <= mode;
                    end
                end
                S_SEND: begin
                    if (!en) abort_pend <= 1'b1;
                end
                S_WAIT: begin
                    wait_cnt <= wait_cnt + 1'b1;
                    if (!en) abort_pend <= 1'b1;
                    if (done_now || timeout_now) begin
                        rdy1 <= 1'b0;
                        rdy2 <= 1'b0;
                    end
                    if (timeout_now) error <= 1'b1;
                    if (done_now && !abort_now && (tag == T_PAY)) slot_cnt <= slot_cnt + 1'b1;
                    if (done_now && (tag == T_CHK)) frames_sent <= frames_sent + 1'b1;
                    if (abort_now) abort_pend <= 1'b0;
                end
                S_CHK: begin
                    data1 <= chk1;
                    data2 <= mode ? chk2 : 8'h00;
                    tag   <= T_CHK;
                    rdy1  <= 1'b1;
                    rdy2  <= mode;
                end
                S_GAP: begin
                    gap_cnt <= gap_cnt + 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_laser_tx_scheduler.sv
// Directed bench for laser_tx_scheduler: dual/single frames, padding, done timeout,
// enable drop in LOAD and reset during WAIT.
module tb_laser_tx_scheduler;

    localparam int unsigned FL = 2;
    localparam int unsigned PT = 8;
    localparam int unsigned DT = 20;
    localparam int unsigned GC = 4;

    logic        clock;
    logic        reset;
    logic        en;
    logic        dual_lane;
    logic        frame_active;
    logic        frame_abort;
    logic        error;
    logic [15:0] frames_sent;

    int errors = 0;
    int checks = 0;

    laser_tx_scheduler_if bus ();

    laser_tx_scheduler #(
        .FRAME_LEN    (FL),
        .PAD_TIMEOUT  (PT),
        .DONE_TIMEOUT (DT),
        .GAP_CYCLES   (GC)
    ) dut (
        .clock        (clock),
        .reset        (reset),
        .en           (en),
        .dual_lane    (dual_lane),
        .bus          (bus),
        .frame_active (frame_active),
        .frame_abort  (frame_abort),
        .error        (error),
        .frames_sent  (frames_sent)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic start_frame(input logic dual, input logic [7:0] b);
        dual_lane    = dual;
        bus.in_data  = b;
        bus.in_valid = 1'b1;
        @(negedge clock);
        bus.in_valid = 1'b0;
        check("sof_active", {15'd0, frame_active}, 16'd1);
    endtask

    task automatic put_byte(input logic [7:0] b);
        int unsigned n = 0;
        while (!bus.in_ready && n < 200) begin
            @(negedge clock);
            n++;
        end
        check("in_ready_wait", {15'd0, bus.in_ready}, 16'd1);
        bus.in_data  = b;
        bus.in_valid = 1'b1;
        @(negedge clock);
        bus.in_valid = 1'b0;
    endtask

    task automatic xfer(input string tag, input logic [7:0] e1, input logic [7:0] e2,
                        input logic er2);
        int unsigned n = 0;
        while (!bus.data1_ready && n < 200) begin
            @(negedge clock);
            n++;
        end
        check({tag, "_rdy1"}, {15'd0, bus.data1_ready}, 16'd1);
        check({tag, "_d1"}, {8'd0, bus.data1_transmit}, {8'd0, e1});
        check({tag, "_d2"}, {8'd0, bus.data2_transmit}, {8'd0, e2});
        check({tag, "_rdy2"}, {15'd0, bus.data2_ready}, {15'd0, er2});
        repeat (3) @(negedge clock);
        check({tag, "_held"}, {7'd0, bus.data1_ready, bus.data1_transmit}, {7'd0, 1'b1, e1});
        bus.tx_done = 1'b1;
        @(negedge clock);
        bus.tx_done = 1'b0;
        check({tag, "_drop"}, {14'd0, bus.data1_ready, bus.data2_ready}, 16'd0);
    endtask

    initial begin
        reset        = 1'b1;
        en           = 1'b0;
        dual_lane    = 1'b0;
        bus.in_data  = 8'h00;
        bus.in_valid = 1'b0;
        bus.tx_done  = 1'b0;
        repeat (3) @(negedge clock);
        check("rst_ready", {14'd0, bus.data1_ready, bus.data2_ready}, 16'd0);
        check("rst_data", {bus.data1_transmit, bus.data2_transmit}, 16'd0);
        check("rst_flags", {13'd0, frame_active, frame_abort, error}, 16'd0);
        check("rst_frames", frames_sent, 16'd0);
        reset = 1'b0;
        en    = 1'b1;
        @(negedge clock);
        check("idle_in_ready", {15'd0, bus.in_ready}, 16'd0);

        // Dual-lane frame: 11,22,33,44
        start_frame(1'b1, 8'h11);
        xfer("d_hdr", 8'hA5, 8'hA5, 1'b1);
        put_byte(8'h11);
        put_byte(8'h22);
        check("d_in_ready_drop", {15'd0, bus.in_ready}, 16'd0);
        xfer("d_p0", 8'h11, 8'h22, 1'b1);
        put_byte(8'h33);
        put_byte(8'h44);
        xfer("d_p1", 8'h33, 8'h44, 1'b1);
        xfer("d_chk", 8'h22, 8'h66, 1'b1);
        check("d_frames", frames_sent, 16'd1);
        check("d_active_off", {15'd0, frame_active}, 16'd0);
        repeat (8) @(negedge clock);

        // Single-lane frame: 12,34
        start_frame(1'b0, 8'h12);
        xfer("s_hdr", 8'hA5, 8'h00, 1'b0);
        put_byte(8'h12);
        xfer("s_p0", 8'h12, 8'h00, 1'b0);
        put_byte(8'h34);
        xfer("s_p1", 8'h34, 8'h00, 1'b0);
        xfer("s_chk", 8'h26, 8'h00, 1'b0);
        check("s_frames", frames_sent, 16'd2);
        repeat (8) @(negedge clock);

        // Dual-lane with host stall after 55: lane 2 padded
        start_frame(1'b1, 8'h55);
        xfer("p_hdr", 8'hA5, 8'hA5, 1'b1);
        put_byte(8'h55);
        repeat (PT - 2) @(negedge clock);
        check("p_not_yet", {15'd0, bus.data1_ready}, 16'd0);
        xfer("p_p0", 8'h55, 8'h00, 1'b1);
        put_byte(8'h77);
        put_byte(8'h88);
        xfer("p_p1", 8'h77, 8'h88, 1'b1);
        xfer("p_chk", 8'h22, 8'h88, 1'b1);
        check("p_frames", frames_sent, 16'd3);
        repeat (8) @(negedge clock);

        // Done timeout after SOF
        start_frame(1'b1, 8'h01);
        begin
            int unsigned n = 0;
            while (!bus.data1_ready && n < 50) begin
                @(negedge clock);
                n++;
            end
        end
        check("to_rdy", {15'd0, bus.data1_ready}, 16'd1);
        repeat (DT) @(negedge clock);
        check("to_err_early", {15'd0, error}, 16'd0);
        @(negedge clock);
        check("to_err", {15'd0, error}, 16'd1);
        check("to_abort", {15'd0, frame_abort}, 16'd1);
        check("to_ready_low", {14'd0, bus.data1_ready, bus.data2_ready}, 16'd0);
        @(negedge clock);
        check("to_abort_pulse", {15'd0, frame_abort}, 16'd0);
        bus.in_valid = 1'b1;
        repeat (10) @(negedge clock);
        check("to_locked", {14'd0, frame_active, bus.in_ready}, 16'd0);
        check("to_sticky", {15'd0, error}, 16'd1);
        bus.in_valid = 1'b0;
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        check("to_err_clear", {15'd0, error}, 16'd0);

        // Reset asserted during WAIT
        start_frame(1'b1, 8'h02);
        @(negedge clock);
        check("rw_send", {15'd0, bus.data1_ready}, 16'd1);
        @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        check("rw_ready", {14'd0, bus.data1_ready, bus.data2_ready}, 16'd0);
        check("rw_data", {bus.data1_transmit, bus.data2_transmit}, 16'd0);
        check("rw_flags", {13'd0, frame_active, frame_abort, error}, 16'd0);
        reset = 1'b0;
        @(negedge clock);

        // Fresh frame, then enable dropped in LOAD with one byte taken
        start_frame(1'b1, 8'h99);
        xfer("e_hdr", 8'hA5, 8'hA5, 1'b1);
        put_byte(8'h99);
        en = 1'b0;
        @(negedge clock);
        check("e_abort", {15'd0, frame_abort}, 16'd1);
        check("e_active", {15'd0, frame_active}, 16'd0);
        @(negedge clock);
        check("e_abort_pulse", {15'd0, frame_abort}, 16'd0);
        check("e_frames", frames_sent, 16'd0);
        check("e_no_ready", {15'd0, bus.data1_ready}, 16'd0);
        en = 1'b1;
        @(negedge clock);

        // Next frame unaffected by the discarded byte
        start_frame(1'b1, 8'h01);
        xfer("n_hdr", 8'hA5, 8'hA5, 1'b1);
        put_byte(8'h01);
        put_byte(8'h02);
        xfer("n_p0", 8'h01, 8'h02, 1'b1);
        put_byte(8'h03);
        put_byte(8'h04);
        xfer("n_p1", 8'h03, 8'h04, 1'b1);
        xfer("n_chk", 8'h02, 8'h06, 1'b1);
        check("n_frames", frames_sent, 16'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
